// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encodings, FSM states and op classification.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_t;

  function automatic logic is_iterative(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared shift register and step counter for shift-add multiply (mode=0)
// and restoring unsigned divide (mode=1).
module alu_iter_unit #(
  parameter int unsigned NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                mode,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                step_en,
  output logic [NUM_BITS-1:0] prod_hi,
  output logic [NUM_BITS-1:0] prod_lo,
  output logic [NUM_BITS-1:0] quot,
  output logic [NUM_BITS-1:0] rem,
  output logic                last
);

  localparam int unsigned CW = $clog2(NUM_BITS + 1);

  logic [NUM_BITS-1:0] hi, lo, dvs;
  logic [NUM_BITS-1:0] src_hi, src_lo, src_dvs;
  logic [NUM_BITS-1:0] nxt_hi, nxt_lo, diff;
  logic [NUM_BITS:0]   sum, tmp;
  logic                mode_q, src_mode;
  logic [CW-1:0]       cnt;

  // The load edge already performs step 1 on the fresh operands, so the
  // remaining NUM_BITS-1 steps fit in ITER and the result is ready in FINISH.
  always_comb begin
    src_hi   = load ? '0 : hi;
    src_lo   = load ? a : lo;
    src_dvs  = load ? b : dvs;
    src_mode = load ? mode : mode_q;
    sum      = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_dvs} : '0);
    tmp      = {src_hi, src_lo[NUM_BITS-1]};
    diff     = tmp[NUM_BITS-1:0] - src_dvs;
    if (!src_mode) begin
      nxt_hi = sum[NUM_BITS:1];
      nxt_lo = {sum[0], src_lo[NUM_BITS-1:1]};
    end else if (tmp >= {1'b0, src_dvs}) begin
      nxt_hi = diff;
      nxt_lo = {src_lo[NUM_BITS-2:0], 1'b1};
    end else begin
      nxt_hi = tmp[NUM_BITS-1:0];
      nxt_lo = {src_lo[NUM_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      hi     <= nxt_hi;
      lo     <= nxt_lo;
      dvs    <= b;
      mode_q <= mode;
      cnt    <= CW'(1);
    end else if (step_en) begin
      hi     <= nxt_hi;
      lo     <= nxt_lo;
      cnt    <= cnt + 1'b1;
    end
  end

  assign last    = (cnt == CW'(NUM_BITS - 1));
  assign prod_hi = hi;
  assign prod_lo = lo;
  assign quot    = lo;
  assign rem     = hi;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: start/done handshake, single-cycle datapath for simple ops,
// iterative unit for mul/div/mod, registered result and N/Z/C/V flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic [3:0]          S,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] R,
  output logic                N,
  output logic                Z,
  output logic                C,
  output logic                V
);

  localparam int unsigned MSB = NUM_BITS - 1;

  state_t              state, state_next;
  alu_op_t             op_in, op_q;
  logic                load, step_en, launch_one, last, b_zero;
  logic [NUM_BITS-1:0] prod_hi, prod_lo, quot, rem;
  logic [NUM_BITS-1:0] one_r, fin_r;
  logic                one_c, one_v, fin_c, fin_v;
  logic [NUM_BITS:0]   add_s, sub_s;

  assign op_in  = alu_op_t'(S);
  assign b_zero = (B == '0);
  assign busy   = (state != IDLE);

  alu_iter_unit #(.NUM_BITS(NUM_BITS)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .mode    (op_in != OP_MUL),
    .a       (A),
    .b       (B),
    .step_en (step_en),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .quot    (quot),
    .rem     (rem),
    .last    (last)
  );

  always_comb begin
    add_s = {1'b0, A} + {1'b0, B};
    sub_s = {1'b0, A} + {1'b0, ~B} + (NUM_BITS + 1)'(1);
    one_r = '0;
    one_c = 1'b0;
    one_v = 1'b0;
    case (op_in)
      OP_ADD: begin
        one_r = add_s[MSB:0];
        one_c = add_s[NUM_BITS];
        one_v = (A[MSB] == B[MSB]) && (add_s[MSB] != A[MSB]);
      end
      OP_SUB: begin
        one_r = sub_s[MSB:0];
        one_c = sub_s[NUM_BITS];
        one_v = (A[MSB] != B[MSB]) && (sub_s[MSB] != A[MSB]);
      end
      // div/mod only reach this path when dividing by zero
      OP_DIV: begin
        one_r = '1;
        one_v = 1'b1;
      end
      OP_MOD: begin
        one_r = A;
        one_v = 1'b1;
      end
      OP_AND: one_r = A & B;
      OP_OR:  one_r = A | B;
      OP_XOR: one_r = A ^ B;
      OP_SHL: begin
        one_r = {A[MSB-1:0], 1'b0};
        one_c = A[MSB];
      end
      OP_SHR: begin
        one_r = {1'b0, A[MSB:1]};
        one_c = A[0];
      end
      default: one_v = 1'b1;
    endcase
  end

  always_comb begin
    fin_r = prod_lo;
    fin_c = 1'b0;
    fin_v = 1'b0;
    case (op_q)
      OP_MUL:  fin_v = (prod_hi != '0);
      OP_DIV:  fin_r = quot;
      OP_MOD:  fin_r = rem;
      default: fin_r = prod_lo;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    launch_one = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_iterative(op_in) && !(b_zero && (op_in != OP_MUL))) begin
            load       = 1'b1;
            state_next = ITER;
          end else begin
            launch_one = 1'b1;
          end
        end
      end
      ITER: begin
        step_en = 1'b1;
        if (last) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R    <= '0;
      N    <= 1'b0;
      Z    <= 1'b0;
      C    <= 1'b0;
      V    <= 1'b0;
      done <= 1'b0;
      op_q <= OP_ADD;
    end else begin
      done <= 1'b0;
      if (load) op_q <= op_in;
      if (launch_one) begin
        R    <= one_r;
        N    <= one_r[MSB];
        Z    <= (one_r == '0);
        C    <= one_c;
        V    <= one_v;
        done <= 1'b1;
      end else if (state == FINISH) begin
        R    <= fin_r;
        N    <= fin_r[MSB];
        Z    <= (fin_r == '0);
        C    <= fin_c;
        V    <= fin_v;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (NUM_BITS=4): drivers queue expected responses,
// a negedge monitor pops one per done pulse and checks value and latency.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A = '0, B = '0, S = '0;
  logic       busy, done, N, Z, C, V;
  logic [3:0] R;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] q_exp[$];
  int         q_due[$];
  string      q_name[$];

  logic [7:0] m_exp;
  int         m_due;
  string      m_name;

  alu_seq #(.NUM_BITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .S     (S),
    .busy  (busy),
    .done  (done),
    .R     (R),
    .N     (N),
    .Z     (Z),
    .C     (C),
    .V     (V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (q_exp.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done with R=%b at cycle %0d, expected no done", R, cyc);
      end else begin
        m_exp  = q_exp.pop_front();
        m_due  = q_due.pop_front();
        m_name = q_name.pop_front();
        if ({R, N, Z, C, V} !== m_exp) begin
          failures++;
          $display("FAIL %s value: got R=%b NZCV=%b%b%b%b, expected R=%b NZCV=%b",
                   m_name, R, N, Z, C, V, m_exp[7:4], m_exp[3:0]);
        end
        checks++;
        if (cyc != m_due) begin
          failures++;
          $display("FAIL %s latency: done at cycle %0d, expected cycle %0d", m_name, cyc, m_due);
        end
      end
    end
  end

  task automatic push(input string name, input logic [3:0] r, input logic [3:0] nzcv, input int due);
    q_exp.push_back({r, nzcv});
    q_due.push_back(due);
    q_name.push_back(name);
  endtask

  task automatic flush();
    q_exp.delete();
    q_due.delete();
    q_name.delete();
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (q_exp.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout: got %0d pending results, expected 0", name, q_exp.size());
      flush();
    end
  endtask

  // Launch one op, scramble inputs right after launch, wait for its result and count busy cycles.
  task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] r, input logic [3:0] nzcv, input int lat, input int exp_busy);
    int  bcnt = 0;
    bit  ok = 1'b0;
    @(negedge clk);
    A = a; B = b; S = op; start = 1'b1;
    push(name, r, nzcv, cyc + lat);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        A = ~a;
        B = a;
        S = 4'b0101;
      end
      if (busy === 1'b1) bcnt++;
      #1;
      if (q_exp.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout: got no done, expected done within 30 cycles", name);
      flush();
    end
    checks++;
    if (bcnt != exp_busy) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, bcnt, exp_busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, R, N, Z, C, V} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b R=%b NZCV=%b%b%b%b, expected all zero",
               busy, done, R, N, Z, C, V);
    end
    rst = 1'b0;

    //      name        op      A      B      R      NZCV   lat busy
    run_op("add_9_6",   OP_ADD, 4'd9,  4'd6,  4'b1111, 4'b1000, 1, 0);
    run_op("add_8_8",   OP_ADD, 4'd8,  4'd8,  4'b0000, 4'b0111, 1, 0);
    run_op("sub_10_3",  OP_SUB, 4'd10, 4'd3,  4'b0111, 4'b0011, 1, 0);
    run_op("sub_3_10",  OP_SUB, 4'd3,  4'd10, 4'b1001, 4'b1001, 1, 0);
    run_op("sub_5_5",   OP_SUB, 4'd5,  4'd5,  4'b0000, 4'b0110, 1, 0);
    run_op("mul_5_2",   OP_MUL, 4'd5,  4'd2,  4'b1010, 4'b1000, 5, 4);
    run_op("mul_4_5",   OP_MUL, 4'd4,  4'd5,  4'b0100, 4'b0001, 5, 4);
    run_op("mul_15_15", OP_MUL, 4'd15, 4'd15, 4'b0001, 4'b0001, 5, 4);
    run_op("mul_0_7",   OP_MUL, 4'd0,  4'd7,  4'b0000, 4'b0100, 5, 4);
    run_op("div_15_3",  OP_DIV, 4'd15, 4'd3,  4'b0101, 4'b0000, 5, 4);
    run_op("mod_10_6",  OP_MOD, 4'd10, 4'd6,  4'b0100, 4'b0000, 5, 4);
    run_op("div_3_5",   OP_DIV, 4'd3,  4'd5,  4'b0000, 4'b0100, 5, 4);
    run_op("mod_3_5",   OP_MOD, 4'd3,  4'd5,  4'b0011, 4'b0000, 5, 4);
    run_op("div_14_1",  OP_DIV, 4'd14, 4'd1,  4'b1110, 4'b1000, 5, 4);
    run_op("div_7_0",   OP_DIV, 4'd7,  4'd0,  4'b1111, 4'b1001, 1, 0);
    run_op("mod_9_0",   OP_MOD, 4'd9,  4'd0,  4'b1001, 4'b1001, 1, 0);
    run_op("and",       OP_AND, 4'd12, 4'd10, 4'b1000, 4'b1000, 1, 0);
    run_op("or",        OP_OR,  4'd5,  4'd3,  4'b0111, 4'b0000, 1, 0);
    run_op("xor",       OP_XOR, 4'd15, 4'd10, 4'b0101, 4'b0000, 1, 0);
    run_op("xor_zero",  OP_XOR, 4'd6,  4'd6,  4'b0000, 4'b0100, 1, 0);
    run_op("shl_9",     OP_SHL, 4'd9,  4'd0,  4'b0010, 4'b0010, 1, 0);
    run_op("shl_4",     OP_SHL, 4'd4,  4'd0,  4'b1000, 4'b1000, 1, 0);
    run_op("shr_9",     OP_SHR, 4'd9,  4'd0,  4'b0100, 4'b0010, 1, 0);
    run_op("shr_8",     OP_SHR, 4'd8,  4'd0,  4'b0100, 4'b0000, 1, 0);
    run_op("illegal_a", 4'b1010, 4'd7, 4'd3,  4'b0000, 4'b0101, 1, 0);
    run_op("illegal_f", 4'b1111, 4'd9, 4'd9,  4'b0000, 4'b0101, 1, 0);

    // start held high while busy must be ignored
    @(negedge clk);
    A = 4'd4; B = 4'd3; S = OP_MUL; start = 1'b1;
    push("mul_4_3_busy", 4'b1100, 4'b1000, cyc + 5);
    @(negedge clk);
    A = 4'd1; B = 4'd1; S = OP_ADD;
    @(negedge clk);
    A = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_drain("mul_4_3_busy");

    // back-to-back launches in the done cycle
    @(negedge clk);
    A = 4'd5; B = 4'd2; S = OP_MUL; start = 1'b1;
    push("b2b_mul", 4'b1010, 4'b1000, cyc + 5);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL b2b_wait: got no done, expected done within 20 cycles");
    end
    A = 4'd2; B = 4'd3; S = OP_ADD; start = 1'b1;
    push("b2b_add", 4'b0101, 4'b0000, cyc + 1);
    @(negedge clk);
    A = 4'd5; B = 4'd5; S = OP_SUB;
    push("b2b_sub", 4'b0000, 4'b0110, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_drain("b2b");

    // reset two cycles into a divide aborts it silently
    @(negedge clk);
    A = 4'd15; B = 4'd3; S = OP_DIV; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, R, N, Z, C, V} !== 10'b0) begin
      failures++;
      $display("FAIL abort_reset: got busy=%b done=%b R=%b NZCV=%b%b%b%b, expected all zero",
               busy, done, R, N, Z, C, V);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op("add_1_1", OP_ADD, 4'd1, 4'd1, 4'b0010, 4'b0000, 1, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
